// File: rtl/switch_mode_ctrl.sv
// switch_mode_ctrl: debounces the ON/OFF and three animation-select switches
// and drives a small display-mode state machine with registered decoded outputs.
// Optional feature: define ERROR_LATCH_EN to make the ERROR state sticky until
// every animation switch is released or the board is switched off.
// Note: CNT_W must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
module switch_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw,
    output logic [2:0] mode,
    output logic [2:0] anim_en,
    output logic       name_en,
    output logic       err,
    output logic       mode_chg
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_NORMAL = 3'd1,
        ST_ANIM1  = 3'd2,
        ST_ANIM2  = 3'd3,
        ST_ANIM3  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam int NSW = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Switches without a function; named so lint treats them as intentionally unused.
    logic sw_unused;
    assign sw_unused = &{1'b0, sw[6:1]};

    // Bit order: [0]=on, [1]=anim1, [2]=anim2, [3]=anim3.
    logic [NSW-1:0] sw_used;
    assign sw_used = {sw[9], sw[8], sw[7], sw[0]};

    logic [NSW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NSW-1:0] deb_vec;

    // Two-stage synchronizer input for each used switch.
    always_comb begin
        sync1_d = sw_used;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSW; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             deb_q, deb_d;

            // Count cycles of a stable disagreement; a pending toggle (first stage
            // differing from the second) restarts the count so that a clean edge
            // is accepted after exactly DEBOUNCE_CYCLES cycles.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if ((sync2_q[gi] == deb_q) || (sync1_q[gi] != sync2_q[gi])) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d = sync2_q[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Debounce counter and accepted switch level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign deb_vec[gi] = deb_q;
        end
    endgenerate

    logic       sw_on, sw_a1, sw_a2, sw_a3;
    logic [1:0] anim_sum;
    assign sw_on    = deb_vec[0];
    assign sw_a1    = deb_vec[1];
    assign sw_a2    = deb_vec[2];
    assign sw_a3    = deb_vec[3];
    assign anim_sum = {1'b0, sw_a1} + {1'b0, sw_a2} + {1'b0, sw_a3};

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d, anim_en_q, anim_en_d;
    logic       name_en_q, name_en_d, err_q, err_d, mode_chg_q, mode_chg_d;

    // Next state by priority, then decode of that next state so every output
    // register changes on the same edge as the state register.
    always_comb begin
        state_d = ST_NORMAL;
        if (!sw_on) begin
            state_d = ST_OFF;
        end else if (anim_sum > 2'd1) begin
            state_d = ST_ERROR;
`ifdef ERROR_LATCH_EN
        end else if ((state_q == ST_ERROR) && (anim_sum != 2'd0)) begin
            state_d = ST_ERROR;
`endif
        end else if (sw_a3) begin
            state_d = ST_ANIM3;
        end else if (sw_a2) begin
            state_d = ST_ANIM2;
        end else if (sw_a1) begin
            state_d = ST_ANIM1;
        end

        mode_d     = state_d;
        anim_en_d  = 3'b000;
        name_en_d  = 1'b0;
        err_d      = 1'b0;
        mode_chg_d = (state_d != state_q);
        case (state_d)
            ST_NORMAL: name_en_d = 1'b1;
            ST_ANIM1:  anim_en_d = 3'b001;
            ST_ANIM2:  anim_en_d = 3'b010;
            ST_ANIM3:  anim_en_d = 3'b100;
            ST_ERROR:  err_d     = 1'b1;
            default:   ;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            mode_q     <= 3'd0;
            anim_en_q  <= 3'b000;
            name_en_q  <= 1'b0;
            err_q      <= 1'b0;
            mode_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            anim_en_q  <= anim_en_d;
            name_en_q  <= name_en_d;
            err_q      <= err_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    assign mode     = mode_q;
    assign anim_en  = anim_en_q;
    assign name_en  = name_en_q;
    assign err      = err_q;
    assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_switch_mode_ctrl.sv
// Testbench for switch_mode_ctrl: directed steps followed by random switch
// activity, every cycle compared against a window-based reference model.
module tb_switch_mode_ctrl;

    localparam int D = 4;
`ifdef ERROR_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw;
    logic [2:0] mode, anim_en;
    logic       name_en, err, mode_chg;

    switch_mode_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .mode     (mode),
        .anim_en  (anim_en),
        .name_en  (name_en),
        .err      (err),
        .mode_chg (mode_chg)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int chg_seen = 0;

    // Reference model: a switch level is accepted once the last D+1 samples
    // taken at the pins (delayed one cycle by the synchronizer) all agree.
    logic [9:0] hist[$];
    bit         m_deb[4];
    int         m_state;
    int         m_chg;
    int         sw_idx[4] = '{0, 7, 8, 9};

    function automatic int next_mode(input bit on, input bit a1, input bit a2,
                                     input bit a3, input int cur);
        int n;
        n = int'(a1) + int'(a2) + int'(a3);
        if (!on)                            return 0;
        if (n > 1)                          return 5;
        if (LATCH && cur == 5 && n == 1)    return 5;
        if (a3)                             return 4;
        if (a2)                             return 3;
        if (a1)                             return 2;
        return 1;
    endfunction

    function automatic logic [31:0] exp_anim(input int st);
        case (st)
            2:       return 32'd1;
            3:       return 32'd2;
            4:       return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(10'd0);
        for (int i = 0; i < 4; i++) m_deb[i] = 1'b0;
        m_state = 0;
        m_chg   = 0;
    endtask

    task automatic model_step(input logic [9:0] v);
        int ns;
        bit stable;
        bit v0;
        ns      = next_mode(m_deb[0], m_deb[1], m_deb[2], m_deb[3], m_state);
        m_chg   = (ns != m_state) ? 1 : 0;
        m_state = ns;
        hist.push_back(v);
        void'(hist.pop_front());
        for (int i = 0; i < 4; i++) begin
            v0     = hist[0][sw_idx[i]];
            stable = 1'b1;
            for (int j = 1; j <= D; j++)
                if (hist[j][sw_idx[i]] != v0) stable = 1'b0;
            if (stable) m_deb[i] = v0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("mode",     32'(mode),     32'(m_state));
        chk("anim_en",  32'(anim_en),  exp_anim(m_state));
        chk("name_en",  32'(name_en),  (m_state == 1) ? 32'd1 : 32'd0);
        chk("err",      32'(err),      (m_state == 5) ? 32'd1 : 32'd0);
        chk("mode_chg", 32'(mode_chg), 32'(m_chg));
    endtask

    // One clock cycle: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input logic [9:0] v);
        sw = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
        if (mode_chg === 1'b1) chg_seen++;
        check_model();
    endtask

    task automatic do_reset(input logic [9:0] v);
        rst = 1'b1;
        sw  = v;
        #1;
        chk("rst_mode",     32'(mode),     32'd0);
        chk("rst_anim_en",  32'(anim_en),  32'd0);
        chk("rst_name_en",  32'(name_en),  32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_mode_chg", 32'(mode_chg), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] v;
        int hold;
        rst = 1'b1;
        sw  = 10'h000;
        model_reset();
        @(negedge clk);

        // Reset with all switches held high: ERROR after 7 cycles, one pulse.
        do_reset(10'h381);
        chg_seen = 0;
        repeat (6) cyc(10'h381);
        chk("rst_sw_mode_c6", 32'(mode), 32'd0);
        cyc(10'h381);
        chk("rst_sw_mode_c7", 32'(mode), 32'd5);
        chk("rst_sw_err_c7",  32'(err),  32'd1);
        repeat (5) cyc(10'h381);
        chk("rst_sw_pulses", 32'(chg_seen), 32'd1);

        // Turn on from OFF: NORMAL exactly 7 cycles after the edge.
        do_reset(10'h000);
        repeat (3) cyc(10'h000);
        repeat (6) cyc(10'h001);
        chk("on_mode_c6", 32'(mode), 32'd0);
        cyc(10'h001);
        chk("on_mode_c7",    32'(mode),    32'd1);
        chk("on_name_en_c7", 32'(name_en), 32'd1);

        // Three-cycle glitch on sw[8] while in NORMAL is ignored.
        chg_seen = 0;
        repeat (3) cyc(10'h101);
        repeat (10) cyc(10'h001);
        chk("glitch_mode",   32'(mode),     32'd1);
        chk("glitch_pulses", 32'(chg_seen), 32'd0);

        // ANIM1, then sw[9] rises: ERROR.
        repeat (10) cyc(10'h081);
        chk("anim1_mode", 32'(mode), 32'd2);
        repeat (10) cyc(10'h281);
        chk("err_mode",    32'(mode),    32'd5);
        chk("err_anim_en", 32'(anim_en), 32'd0);

        // sw[7] drops out of ERROR.
        repeat (10) cyc(10'h201);
`ifdef ERROR_LATCH_EN
        chk("errx_latched_mode", 32'(mode), 32'd5);
        repeat (10) cyc(10'h001);
        chk("errx_normal_mode", 32'(mode), 32'd1);
`else
        chk("errx_mode",    32'(mode),    32'd4);
        chk("errx_anim_en", 32'(anim_en), 32'd4);
`endif

        // Power off from ANIM2.
        repeat (10) cyc(10'h101);
        chk("anim2_mode", 32'(mode), 32'd3);
        repeat (6) cyc(10'h100);
        chk("off_mode_c6", 32'(mode), 32'd3);
        cyc(10'h100);
        chk("off_mode_c7",    32'(mode),    32'd0);
        chk("off_anim_en_c7", 32'(anim_en), 32'd0);

        // Reset in the middle of a power-off count.
        repeat (10) cyc(10'h101);
        chk("anim2b_mode", 32'(mode), 32'd3);
        repeat (4) cyc(10'h100);
        do_reset(10'h100);
        chg_seen = 0;
        repeat (15) cyc(10'h100);
        chk("midrst_mode",   32'(mode),     32'd0);
        chk("midrst_pulses", 32'(chg_seen), 32'd0);

        // Random switch activity: mostly long holds, some short glitches,
        // occasional resets.
        for (int k = 0; k < 60; k++) begin
            v    = 10'($urandom_range(0, 1023));
            v[0] = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                               : int'($urandom_range(5, 12));
            if ($urandom_range(0, 19) == 0) do_reset(v);
            repeat (hold) cyc(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_mode_ctrl.md
SWITCH_MODE_CTRL -- requirements
Module: switch_mode_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable cycles required to accept a switch change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce counter width; it SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock, the only clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port sw, input, 10 bits: raw board switches; sw[0] is ON/OFF, sw[7], sw[8] and sw[9] select animations 1, 2 and 3, and the other bits are ignored.
REQ-006 The block SHALL have port mode, output, 3 bits: registered display mode, where 0=OFF, 1=NORMAL, 2=ANIM1, 3=ANIM2, 4=ANIM3 and 5=ERROR.
REQ-007 The block SHALL have port anim_en, output, 3 bits: registered one-hot animation enable, where bit0=ANIM1, bit1=ANIM2 and bit2=ANIM3.
REQ-008 The block SHALL have port name_en, output, 1 bit: registered enable for name display, high only in NORMAL.
REQ-009 The block SHALL have port err, output, 1 bit: registered, high only in ERROR.
REQ-010 The block SHALL have port mode_chg, output, 1 bit: a one-cycle pulse in the first cycle a new mode value is visible.

Function
REQ-011 Each used switch (sw[0], sw[7], sw[8], sw[9]) SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized switch SHALL have its own debounce counter and its own debounced bit.
REQ-013 A debounce counter SHALL clear whenever its synchronized input equals its debounced bit, and also whenever the synchronized input toggles.
REQ-014 A debounce counter SHALL otherwise increment by one per cycle.
REQ-015 When a counter reaches DEBOUNCE_CYCLES-1 while still incrementing, its debounced bit SHALL take the synchronized value and the counter SHALL clear in the same cycle.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change a debounced bit, and counters SHALL never wrap.
REQ-017 With debounced bits on, a1, a2 and a3, the state machine SHALL choose its next state, in priority order, as:
  - OFF when on=0;
  - ERROR when a1+a2+a3 > 1 (2-bit sum, no overflow);
  - ANIM3 when a3, else ANIM2 when a2, else ANIM1 when a1;
  - NORMAL otherwise.
REQ-018 The state register SHALL update every cycle; any state may move directly to any other state.
REQ-019 mode, anim_en, name_en and err SHALL be decoded from the state register so that all of them change in the same cycle.
REQ-020 In ERROR, OFF and NORMAL, anim_en SHALL be 000.
REQ-021 Latency from a clean switch edge at the sw pins to the change on mode SHALL be exactly DEBOUNCE_CYCLES+3 cycles: 2 for the synchronizer, DEBOUNCE_CYCLES for the debounce, 1 for the state register.
REQ-022 mode_chg SHALL be high for exactly one cycle when the state register loads a value different from its previous value; it SHALL stay low while the state is unchanged.
REQ-023 When two switches' debounced bits change in the same cycle, only the resulting combined state SHALL be taken, with no intermediate state and a single mode_chg pulse.
REQ-024 Turning on=0 SHALL force OFF from every state, including ERROR, on the next state update.

Reset
REQ-025 Asserting rst SHALL immediately clear the synchronizers, debounced bits, counters and state, giving mode=0, anim_en=000, name_en=0, err=0 and mode_chg=0.
REQ-026 The block SHALL leave reset on the first clk edge after rst deasserts.
REQ-027 Switches held high during reset SHALL be accepted as a normal debounce after reset deasserts.
REQ-028 Asserting rst mid-debounce SHALL discard the partial count.
REQ-029 The OFF state reached through reset SHALL not generate mode_chg.

Configuration
REQ-030 With macro ERROR_LATCH_EN defined, ERROR SHALL be sticky: it exits only when a1=a2=a3=0 (to NORMAL) or when on=0 (to OFF).
REQ-031 With ERROR_LATCH_EN defined, reducing to a single animation switch SHALL keep ERROR.
REQ-032 Without ERROR_LATCH_EN, ERROR SHALL follow REQ-017 combinationally, so that dropping to a single switch moves directly to that animation.

Verification
REQ-033 Directed test (DEBOUNCE_CYCLES=4 in all tests), reset: rst=1 with sw=10'h381, then release -> mode=0 during reset; mode=5 and err=1 after 7 cycles; one mode_chg pulse.
REQ-034 Directed test, turn on: sw=10'h001 from OFF -> mode=1 and name_en=1 exactly 7 cycles after the edge.
REQ-035 Directed test, glitch: sw[8] high for 3 cycles while in NORMAL -> mode stays 1 and mode_chg stays 0.
REQ-036 Directed test, error entry: in ANIM1 (sw=10'h081), sw[9] rises -> mode=5, anim_en=000.
REQ-037 Directed test, error exit: from the REQ-036 state, sw[7] drops -> without the macro mode=4 and anim_en=100; with ERROR_LATCH_EN mode stays 5 until sw[9] also drops, then mode=1.
REQ-038 Directed test, power off: from ANIM2, sw[0] drops -> mode=0 and anim_en=000 after 7 cycles; asserting rst during the count -> mode=0 immediately and no later change.
